din_entry: RTL

Board-side input path for the simple processor: the inverse of the register-to-HEX display path. It debounces a push-button and captures a 16-bit word from the switches. It then launches one processor instruction by pulsing `Run` while holding the word on `DIN`, and waits for `Done`. A second press during execution replaces `DIN`, which supplies the immediate word for `mvi`.

---
 rtl/din_entry.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/din_entry.sv
// din_entry: debounced key + switch capture that launches one processor instruction (Run/Done handshake).
// Optional Done timeout with sticky Error is compiled in by defining DIN_ENTRY_TIMEOUT_EN.
module din_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        KeyN,
  input  logic [15:0] SwWord,
  input  logic        Done,
  output logic [15:0] DIN,
  output logic        Run,
  output logic        Busy,
  output logic [7:0]  Count,
  output logic        Error
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t         state_r;
  logic           sync1_r;
  logic           sync2_r;
  logic           deb_r;
  logic           deb_d_r;
  logic           press_r;
  logic [DCW-1:0] deb_cnt_r;
  logic           timeout_s;

  // two-flop synchronizer on the inverted (active-high) key
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= ~KeyN;
      sync2_r <= sync1_r;
    end
  end

  // debounce counter: the level only moves after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      deb_r     <= 1'b0;
      deb_cnt_r <= {DCW{1'b0}};
    end else if (sync2_r == deb_r) begin
      deb_cnt_r <= {DCW{1'b0}};
    end else if (deb_cnt_r == DCW'(DEBOUNCE_CYCLES - 1)) begin
      deb_r     <= sync2_r;
      deb_cnt_r <= {DCW{1'b0}};
    end else begin
      deb_cnt_r <= deb_cnt_r + DCW'(1);
    end
  end

  // one-cycle press pulse on the rising edge of the debounced level; release is silent
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      deb_d_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      deb_d_r <= deb_r;
      press_r <= deb_r & ~deb_d_r;
    end
  end

`ifdef DIN_ENTRY_TIMEOUT_EN
  logic [15:0] wait_cnt_r;

  assign timeout_s = (state_r == ST_WAIT) && (wait_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // cycles spent in WAIT; cleared in every other state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt_r <= 16'h0000;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 16'h0001;
    end else begin
      wait_cnt_r <= 16'h0000;
    end
  end

  // sticky timeout flag; a Done in the timeout cycle is a normal completion
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Error <= 1'b0;
    end else if (timeout_s && !Done) begin
      Error <= 1'b1;
    end else begin
      Error <= Error;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_s = 1'b0;
  assign Error     = 1'b0;
`endif

  // instruction launch FSM with registered Run/Busy/DIN/Count
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      DIN     <= 16'h0000;
      Run     <= 1'b0;
      Busy    <= 1'b0;
      Count   <= 8'h00;
    end else begin
      Run <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (press_r) begin
            DIN     <= SwWord;
            Run     <= 1'b1;
            Busy    <= 1'b1;
            state_r <= ST_LAUNCH;
          end else begin
            Busy <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          Busy    <= 1'b1;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done outranks both the timeout and a simultaneous press
          if (Done) begin
            Count   <= Count + 8'd1;
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (timeout_s) begin
            Busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (press_r) begin
            DIN  <= SwWord;
            Busy <= 1'b1;
          end else begin
            Busy <= 1'b1;
          end
        end
        default: begin
          Busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
